// File: rtl/bram_group_arb.sv
// Purpose: BANK_NUM simple-dual-port banks with per-unit write masks; each bank's read port is shared by READ_PORT_NUM requesters through a round-robin arbiter.
// Latency: grant is combinational; rd_valid_o / read_data_o follow READ_LATENCY cycles after the grant, one pulse per grant.
// Backpressure: a requester holds rd_req/rd_addr until rd_gnt_o; ungranted requests leave no state behind.

// Storage for one bank plus its read-data delay line. The generate branches only
// differ in the implementation hint given to the memory array.
module bram_group_arb_ram #(
    parameter int    UNIT_NUM   = 8,
    parameter int    UNIT_WIDTH = 8,
    parameter int    ADDR_WIDTH = 12,
    parameter int    LATENCY    = 2,
    parameter string PRIMITIVE  = "ultra"
) (
    input  logic                           clk,
    input  logic [UNIT_NUM-1:0]            wr_mask,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [UNIT_NUM*UNIT_WIDTH-1:0] wr_data,
    input  logic                           rd_en,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [UNIT_NUM*UNIT_WIDTH-1:0] rd_data
);
    localparam int DW    = UNIT_NUM * UNIT_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // First read stage; the memory read and write share an edge, so a
    // same-address collision returns the previous contents.
    logic [DW-1:0] rd_q;

    if (PRIMITIVE == "block") begin : g_block
        (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];

        // Masked write: only enabled units are updated.
        always_ff @(posedge clk) begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                if (wr_mask[u]) mem[wr_addr][u*UNIT_WIDTH +: UNIT_WIDTH] <= wr_data[u*UNIT_WIDTH +: UNIT_WIDTH];
            end
        end

        // Read-first registered read.
        always_ff @(posedge clk) begin
            if (rd_en) rd_q <= mem[rd_addr];
        end
    end else if (PRIMITIVE == "distributed") begin : g_dist
        (* ram_style = "distributed" *) logic [DW-1:0] mem [DEPTH];

        // Masked write: only enabled units are updated.
        always_ff @(posedge clk) begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                if (wr_mask[u]) mem[wr_addr][u*UNIT_WIDTH +: UNIT_WIDTH] <= wr_data[u*UNIT_WIDTH +: UNIT_WIDTH];
            end
        end

        // Read-first registered read.
        always_ff @(posedge clk) begin
            if (rd_en) rd_q <= mem[rd_addr];
        end
    end else if (PRIMITIVE == "auto") begin : g_auto
        (* ram_style = "auto" *) logic [DW-1:0] mem [DEPTH];

        // Masked write: only enabled units are updated.
        always_ff @(posedge clk) begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                if (wr_mask[u]) mem[wr_addr][u*UNIT_WIDTH +: UNIT_WIDTH] <= wr_data[u*UNIT_WIDTH +: UNIT_WIDTH];
            end
        end

        // Read-first registered read.
        always_ff @(posedge clk) begin
            if (rd_en) rd_q <= mem[rd_addr];
        end
    end else begin : g_ultra
        (* ram_style = "ultra" *) logic [DW-1:0] mem [DEPTH];

        // Masked write: only enabled units are updated.
        always_ff @(posedge clk) begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                if (wr_mask[u]) mem[wr_addr][u*UNIT_WIDTH +: UNIT_WIDTH] <= wr_data[u*UNIT_WIDTH +: UNIT_WIDTH];
            end
        end

        // Read-first registered read.
        always_ff @(posedge clk) begin
            if (rd_en) rd_q <= mem[rd_addr];
        end
    end

    // Remaining LATENCY-1 stages carry data unconditionally; the top gates
    // the output with the valid tag, so stale data never escapes.
    if (LATENCY > 1) begin : g_dly
        logic [DW-1:0] dly [LATENCY-1];

        // Plain shift register, no reset needed on the data path.
        always_ff @(posedge clk) begin
            dly[0] <= rd_q;
            for (int s = 1; s < LATENCY-1; s++) dly[s] <= dly[s-1];
        end

        assign rd_data = dly[LATENCY-2];
    end else begin : g_nodly
        assign rd_data = rd_q;
    end
endmodule

module bram_group_arb #(
    parameter int    BANK_NUM           = 4,
    parameter int    BANK_UNIT_NUM      = 8,
    parameter int    BANK_ADDR_WIDTH    = 12,
    parameter int    BANK_UNIT_WIDTH    = 8,
    parameter int    READ_PORT_NUM      = 3,
    parameter int    READ_LATENCY       = 2,
    parameter string MEM_POOL_PRIMITIVE = "ultra"
) (
    input  logic                                                clk,
    input  logic                                                rst_p,
    input  logic [BANK_NUM-1:0]                                 write_bank_en_i,
    input  logic [BANK_NUM*BANK_UNIT_NUM-1:0]                   write_unit_en_i,
    input  logic [BANK_NUM*BANK_ADDR_WIDTH-1:0]                 write_addr_i,
    input  logic [BANK_NUM*BANK_UNIT_WIDTH*BANK_UNIT_NUM-1:0]   write_data_i,
    input  logic [READ_PORT_NUM*BANK_NUM-1:0]                   rd_req_i,
    input  logic [READ_PORT_NUM*BANK_NUM*BANK_ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [READ_PORT_NUM*BANK_NUM-1:0]                   rd_gnt_o,
    output logic [READ_PORT_NUM*BANK_NUM-1:0]                   rd_valid_o,
    output logic [BANK_NUM*BANK_UNIT_WIDTH*BANK_UNIT_NUM-1:0]   read_data_o
);
    localparam int DW    = BANK_UNIT_WIDTH * BANK_UNIT_NUM;
    localparam int AW    = BANK_ADDR_WIDTH;
    localparam int P     = READ_PORT_NUM;
    localparam int PTR_W = (P > 1) ? $clog2(P) : 1;

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        logic [P-1:0]       req;
        logic [P-1:0]       gnt;
        logic [PTR_W-1:0]   ptr;
        logic [PTR_W-1:0]   sel_hi;
        logic [PTR_W-1:0]   sel_lo;
        logic [PTR_W-1:0]   sel;
        logic               hit_hi;
        logic               any_req;
        logic [AW-1:0]      raddr;
        logic               rd_en;
        logic [UNIT_MASK_W(BANK_UNIT_NUM)-1:0] wmask;
        logic [DW-1:0]      ram_data;
        logic [P-1:0]       tag_pipe [READ_LATENCY];
        logic               out_vld;

        // Gather this bank's requests from the p-major request bus.
        for (genvar p = 0; p < P; p++) begin : g_port
            assign req[p]                    = rd_req_i[p*BANK_NUM+b];
            assign rd_gnt_o[p*BANK_NUM+b]    = gnt[p];
            assign rd_valid_o[p*BANK_NUM+b]  = tag_pipe[READ_LATENCY-1][p];
        end

        // Cyclic priority search: the lowest requester at or above ptr wins,
        // otherwise the lowest requester overall (wrap-around).
        always_comb begin
            sel_hi  = '0;
            sel_lo  = '0;
            hit_hi  = 1'b0;
            any_req = 1'b0;
            for (int p = P-1; p >= 0; p--) begin
                if (req[p]) begin
                    sel_lo  = PTR_W'(p);
                    any_req = 1'b1;
                    if (PTR_W'(p) >= ptr) begin
                        sel_hi = PTR_W'(p);
                        hit_hi = 1'b1;
                    end
                end
            end
        end

        assign sel = hit_hi ? sel_hi : sel_lo;

        // One-hot grant (suppressed in reset) and the matching address mux.
        always_comb begin
            gnt   = '0;
            raddr = '0;
            for (int p = 0; p < P; p++) begin
                if (!rst_p && any_req && (sel == PTR_W'(p))) begin
                    gnt[p] = 1'b1;
                    raddr  = rd_addr_i[(p*BANK_NUM+b)*AW +: AW];
                end
            end
        end

        assign rd_en = |gnt;

        // Pointer advances past the granted port; holds when idle.
        always_ff @(posedge clk or posedge rst_p) begin
            if (rst_p) begin
                ptr <= '0;
            end else if (any_req) begin
                ptr <= (sel == PTR_W'(P-1)) ? '0 : sel + PTR_W'(1);
            end
        end

        // Owner tag travels alongside the RAM read and is flushed by reset.
        always_ff @(posedge clk or posedge rst_p) begin
            if (rst_p) begin
                for (int s = 0; s < READ_LATENCY; s++) tag_pipe[s] <= '0;
            end else begin
                tag_pipe[0] <= gnt;
                for (int s = 1; s < READ_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
            end
        end

        assign wmask   = write_bank_en_i[b] ? write_unit_en_i[b*BANK_UNIT_NUM +: BANK_UNIT_NUM] : '0;
        assign out_vld = |tag_pipe[READ_LATENCY-1];

        bram_group_arb_ram #(
            .UNIT_NUM   (BANK_UNIT_NUM),
            .UNIT_WIDTH (BANK_UNIT_WIDTH),
            .ADDR_WIDTH (AW),
            .LATENCY    (READ_LATENCY),
            .PRIMITIVE  (MEM_POOL_PRIMITIVE)
        ) u_ram (
            .clk     (clk),
            .wr_mask (wmask),
            .wr_addr (write_addr_i[b*AW +: AW]),
            .wr_data (write_data_i[b*DW +: DW]),
            .rd_en   (rd_en),
            .rd_addr (raddr),
            .rd_data (ram_data)
        );

        // Data is forced to zero unless this cycle carries a valid tag.
        assign read_data_o[b*DW +: DW] = ram_data & {DW{out_vld}};

        // At most one grant per bank, and only to a requester.
        a_gnt_onehot: assert property (@(posedge clk) disable iff (rst_p) $onehot0(gnt));
        a_gnt_req:    assert property (@(posedge clk) disable iff (rst_p) (gnt & ~req) == '0);
    end

    function automatic int UNIT_MASK_W(input int n);
        return n;
    endfunction
endmodule

// File: tb/tb_bram_group_arb.sv
module tb_bram_group_arb;
    logic         clk = 1'b0;
    logic         rst_p;
    logic [3:0]   write_bank_en_i;
    logic [31:0]  write_unit_en_i;
    logic [47:0]  write_addr_i;
    logic [255:0] write_data_i;
    logic [11:0]  rd_req_i;
    logic [143:0] rd_addr_i;
    logic [11:0]  rd_gnt_o;
    logic [11:0]  rd_valid_o;
    logic [255:0] read_data_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] rr_dat [3];

    bram_group_arb dut (
        .clk             (clk),
        .rst_p           (rst_p),
        .write_bank_en_i (write_bank_en_i),
        .write_unit_en_i (write_unit_en_i),
        .write_addr_i    (write_addr_i),
        .write_data_i    (write_data_i),
        .rd_req_i        (rd_req_i),
        .rd_addr_i       (rd_addr_i),
        .rd_gnt_o        (rd_gnt_o),
        .rd_valid_o      (rd_valid_o),
        .read_data_o     (read_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_inputs();
        write_bank_en_i = '0;
        write_unit_en_i = '0;
        write_addr_i    = '0;
        write_data_i    = '0;
        rd_req_i        = '0;
        rd_addr_i       = '0;
    endtask

    // Move to the next cycle; inputs are cleared so each cycle states its own stimulus.
    task automatic tick();
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic set_wr(input int b, input logic [11:0] addr, input logic [63:0] data, input logic [7:0] mask);
        write_bank_en_i[b]          = 1'b1;
        write_unit_en_i[b*8 +: 8]   = mask;
        write_addr_i[b*12 +: 12]    = addr;
        write_data_i[b*64 +: 64]    = data;
    endtask

    task automatic set_rd(input int p, input int b, input logic [11:0] addr);
        rd_req_i[p*4+b]               = 1'b1;
        rd_addr_i[(p*4+b)*12 +: 12]   = addr;
    endtask

    initial begin
        rr_dat[0] = 64'h1111_2222_3333_0A00;
        rr_dat[1] = 64'h4444_5555_6666_0A01;
        rr_dat[2] = 64'h7777_8888_9999_0A02;

        // ---------------- reset state ----------------
        rst_p = 1'b1;
        clr_inputs();
        repeat (2) @(negedge clk);
        set_rd(0, 0, 12'h000);
        #1;
        chk("rst_gnt",   256'(rd_gnt_o),   256'h0);
        chk("rst_valid", 256'(rd_valid_o), 256'h0);
        chk("rst_data",  read_data_o,      256'h0);
        tick();
        rst_p = 1'b0;

        // ---------------- masked write ----------------
        set_wr(1, 12'h010, 64'h0807060504030201, 8'hFF);
        tick();
        set_wr(1, 12'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        tick();
        set_wr(1, 12'h010, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        tick();
        set_rd(0, 1, 12'h010);
        #1 chk("mw_gnt", 256'(rd_gnt_o), 256'h002);
        tick();
        chk("mw_valid_t1", 256'(rd_valid_o), 256'h0);
        chk("mw_data_t1",  read_data_o,      256'h0);
        tick();
        chk("mw_valid_t2", 256'(rd_valid_o), 256'h002);
        chk("mw_data_t2",  read_data_o,      256'h08070605AAAAAAAA << 64);
        tick();
        chk("mw_valid_t3", 256'(rd_valid_o), 256'h0);

        // ---------------- round-robin on bank 0 ----------------
        for (int p = 0; p < 3; p++) begin
            set_wr(0, 12'h100 + 12'(p), rr_dat[p], 8'hFF);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            logic [11:0]  exp_v;
            logic [255:0] exp_d;
            exp_v = '0;
            exp_d = '0;
            if (k >= 2) begin
                exp_v = 12'h001 << (((k-2) % 3) * 4);
                exp_d = 256'(rr_dat[(k-2) % 3]);
            end
            chk($sformatf("rr_valid_%0d", k), 256'(rd_valid_o), 256'(exp_v));
            chk($sformatf("rr_data_%0d", k),  read_data_o,      exp_d);
            if (k < 6) begin
                for (int p = 0; p < 3; p++) set_rd(p, 0, 12'h100 + 12'(p));
                #1 chk($sformatf("rr_gnt_%0d", k), 256'(rd_gnt_o), 256'(12'h001 << ((k % 3) * 4)));
            end
            tick();
        end

        // ---------------- skip and wrap on bank 3 ----------------
        set_rd(1, 3, 12'h030);
        #1 chk("sw_ptr2", 256'(rd_gnt_o), 256'h080);
        tick();
        set_rd(0, 3, 12'h031);
        set_rd(1, 3, 12'h032);
        #1 chk("sw_skip_p0", 256'(rd_gnt_o), 256'h008);
        tick();
        set_rd(0, 3, 12'h031);
        set_rd(1, 3, 12'h032);
        #1 chk("sw_p1", 256'(rd_gnt_o), 256'h080);
        tick();
        set_rd(0, 3, 12'h031);
        set_rd(1, 3, 12'h032);
        #1 chk("sw_wrap_p0", 256'(rd_gnt_o), 256'h008);
        tick();

        // ---------------- read/write collision on bank 2 ----------------
        set_wr(2, 12'h020, 64'h1111111111111111, 8'hFF);
        tick();
        set_wr(2, 12'h020, 64'h5555555555555555, 8'hFF);
        set_rd(2, 2, 12'h020);
        #1 chk("col_gnt0", 256'(rd_gnt_o), 256'h400);
        tick();
        set_rd(2, 2, 12'h020);
        #1 chk("col_gnt1", 256'(rd_gnt_o), 256'h400);
        tick();
        chk("col_valid_old", 256'(rd_valid_o), 256'h400);
        chk("col_data_old",  256'(read_data_o[128 +: 64]), 256'h1111111111111111);
        tick();
        chk("col_valid_new", 256'(rd_valid_o), 256'h400);
        chk("col_data_new",  256'(read_data_o[128 +: 64]), 256'h5555555555555555);
        tick();

        // ---------------- parallel banks ----------------
        set_rd(0, 0, 12'h100);
        set_rd(1, 1, 12'h010);
        set_rd(2, 2, 12'h020);
        #1 chk("par_gnt", 256'(rd_gnt_o), 256'h421);
        tick();
        chk("par_valid_t1", 256'(rd_valid_o), 256'h0);
        tick();
        chk("par_valid_t2", 256'(rd_valid_o), 256'h421);
        chk("par_data_b0", 256'(read_data_o[0 +: 64]),   256'(rr_dat[0]));
        chk("par_data_b1", 256'(read_data_o[64 +: 64]),  256'h08070605AAAAAAAA);
        chk("par_data_b2", 256'(read_data_o[128 +: 64]), 256'h5555555555555555);
        tick();

        // ---------------- reset mid-flight ----------------
        set_rd(0, 0, 12'h101);
        #1 chk("rf_gnt", 256'(rd_gnt_o), 256'h001);
        tick();
        rst_p = 1'b1;
        set_rd(0, 0, 12'h101);
        #1;
        chk("rf_gnt_in_rst", 256'(rd_gnt_o),   256'h0);
        chk("rf_valid_now",  256'(rd_valid_o), 256'h0);
        chk("rf_data_now",   read_data_o,      256'h0);
        tick();
        chk("rf_no_pulse", 256'(rd_valid_o), 256'h0);
        rst_p = 1'b0;
        tick();
        // bank 0 pointer was 1 before reset; ports 0 and 2 tell 0 from 1 apart
        set_rd(0, 0, 12'h100);
        set_rd(2, 0, 12'h102);
        #1 chk("rf_ptr0_cleared", 256'(rd_gnt_o), 256'h001);
        tick();
        chk("rf_valid_t1", 256'(rd_valid_o), 256'h0);
        tick();
        chk("rf_valid_t2", 256'(rd_valid_o), 256'h001);
        chk("rf_data_t2",  read_data_o,      256'(rr_dat[0]));
        // asynchronous clear of a live valid pulse
        rst_p = 1'b1;
        #1;
        chk("rf_async_valid", 256'(rd_valid_o), 256'h0);
        chk("rf_async_data",  read_data_o,      256'h0);
        tick();
        rst_p = 1'b0;
        // bank 1 pointer was 2 before reset; ports 0 and 2 tell 0 from 2 apart
        set_rd(0, 1, 12'h010);
        set_rd(2, 1, 12'h011);
        #1 chk("rf_ptr1_cleared", 256'(rd_gnt_o), 256'h002);
        tick();
        tick();
        chk("rf_b1_valid", 256'(rd_valid_o), 256'h002);
        chk("rf_b1_data",  read_data_o,      256'h08070605AAAAAAAA << 64);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bram_group_arb.md
# bram_group_arb

Multi-requester successor to the single-port memory-pool bank group. It holds BANK_NUM independent simple-dual-port banks with per-unit write masking. Each bank's read port is shared by READ_PORT_NUM requesters (conv, datasaver, misc, …) through a per-bank round-robin arbiter. Read data is returned with a pipelined valid tag that identifies the owning requester. It sits between mem_pool_top's request routing and the bank RAM primitives.

## Interface
- BANK_NUM, 4, number of banks
- BANK_UNIT_NUM, 8, units per bank word
- BANK_ADDR_WIDTH, 12, bank address width; depth = 2**BANK_ADDR_WIDTH
- BANK_UNIT_WIDTH, 8, bits per unit; DW = BANK_UNIT_WIDTH*BANK_UNIT_NUM
- READ_PORT_NUM, 3, requesters per bank, ≥1
- READ_LATENCY, 2, RAM read latency in cycles, ≥1
- MEM_POOL_PRIMITIVE, "ultra", "ultra"/"block"/"distributed"/"auto"

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_p  in  1  asynchronous, active-high reset
- write_bank_en_i  in  BANK_NUM  per-bank write strobe
- write_unit_en_i  in  BANK_NUM*BANK_UNIT_NUM  per-unit write mask, bank b at [b*UNIT_NUM +: UNIT_NUM]
- write_addr_i  in  BANK_NUM*BANK_ADDR_WIDTH  write address per bank
- write_data_i  in  BANK_NUM*DW  write data per bank
- rd_req_i  in  READ_PORT_NUM*BANK_NUM  request, bit p*BANK_NUM+b = port p to bank b
- rd_addr_i  in  READ_PORT_NUM*BANK_NUM*BANK_ADDR_WIDTH  address, same p-major packing
- rd_gnt_o  out  READ_PORT_NUM*BANK_NUM  combinational grant, same packing
- rd_valid_o  out  READ_PORT_NUM*BANK_NUM  returned-data valid and owner, same packing
- read_data_o  out  BANK_NUM*DW  read data per bank

## Operation
- Write: unit u of bank b is written when write_bank_en_i[b] & write_unit_en_i[b*UNIT_NUM+u]. Unmasked units keep their contents. An all-zero mask performs no write.
- Arbitration per bank: round-robin pointer ptr_b in [0, READ_PORT_NUM-1]. In the cycle of the request, the first requesting port at or after ptr_b (cyclic search) is granted. At most one grant per bank per cycle.
- After a grant to port p, ptr_b ← (p+1) mod READ_PORT_NUM, wrapping from READ_PORT_NUM-1 to 0. With no request, ptr_b holds.
- A request that is not granted has no effect. The requester holds rd_req and rd_addr until granted; the block stores no requests.
- The RAM read enable for bank b is OR of that bank's grants. The address is the granted port's rd_addr (one-hot mux).
- Tag pipeline per bank: a READ_LATENCY-deep shift register carries the one-hot grant vector. Its output drives rd_valid_o for that bank.
- read_data_o[b] is the RAM output ANDed with (|rd_valid_o of bank b). It is 0 whenever there is no valid.
- Read/write collision at the same bank and address in the same cycle is read_first: the read returns the old data.
- READ_PORT_NUM = 1: the pointer is constant 0 and the grant equals the request.
- Memory contents are not reset and are not initialised.

## Timing
- Reset values: rd_valid_o = 0, read_data_o = 0, every ptr_b = 0, tag pipeline cleared. All take effect asynchronously on rst_p assertion.
- Reset is released synchronously to clk by the system. The first grant is possible in the first cycle after deassertion.
- rd_gnt_o is combinational from rd_req_i and ptr_b, with zero cycles latency. During reset, rd_gnt_o = 0.
- A grant at cycle t produces rd_valid_o and read_data_o at cycle t+READ_LATENCY, for exactly one cycle per grant.
- Throughput is one read per bank per cycle. Banks are fully independent. Under continuous contention from k ports, each port is granted once every k cycles.
- A write at cycle t is visible to a read granted at t+1 or later.
- Reset mid-operation: in-flight tags are discarded and no rd_valid_o pulse follows for them. Pointers return to 0.

## Test plan
- Masked write: bank 1, addr 0x010, data 0x0807060504030201, mask 0xFF; then rewrite with data 0xAA.., mask 0x0F; read via port 0 → at t+2, rd_valid_o bit (0*4+1) = 1 and data = 0x08070605AAAAAAAA.
- Round-robin: ports 0, 1 and 2 all request bank 0 continuously from reset → grants 0,1,2,0,1,2…; valids follow the same order 2 cycles later; each port's address reads back its own data.
- Skip and wrap: ptr = 2, only ports 0 and 1 request bank 3 → port 0 granted, ptr = 1; next cycle port 1 granted, ptr = 2.
- Collision: write 0x55.. and read addr 0x020 (old 0x11..) in the same cycle → returns 0x11..; a read one cycle later → returns 0x55...
- Parallel banks: ports 0–2 request banks 0, 1 and 2 simultaneously with distinct addresses → all three granted in the same cycle; three valids at t+2 with correct data.
- Reset mid-flight: grant at t, assert rst_p at t+1 → rd_valid_o and read_data_o are 0 immediately, no valid pulse at t+2, pointers = 0 after release.
